// File: rtl/fifo_sram_writer_if.sv
// fifo_sram_writer_if: FIFO read, allocator, SRAM write and packet report signals of the writer
interface fifo_sram_writer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4,
  parameter int SRAM_AW    = 10
);
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic                  alloc_req;
  logic                  alloc_gnt;
  logic [SRAM_AW-1:0]    alloc_addr;
  logic                  sram_wr_en;
  logic [SRAM_AW-1:0]    sram_addr;
  logic [DATA_WIDTH-1:0] sram_wdata;
  logic                  sram_ready;
  logic                  pkt_done;
  logic [SRAM_AW-1:0]    pkt_base;
  logic [LEN_WIDTH-1:0]  pkt_len;
  logic                  hdr_err;
  modport master (
    input  fifo_dout, fifo_empty, alloc_gnt, alloc_addr, sram_ready,
    output fifo_rd_en, alloc_req, sram_wr_en, sram_addr, sram_wdata, pkt_done, pkt_base, pkt_len, hdr_err
  );
  modport slave (
    output fifo_dout, fifo_empty, alloc_gnt, alloc_addr, sram_ready,
    input  fifo_rd_en, alloc_req, sram_wr_en, sram_addr, sram_wdata, pkt_done, pkt_base, pkt_len, hdr_err
  );
endinterface

// File: rtl/fifo_sram_writer.sv
// fifo_sram_writer: pops length-prefixed packets from an FWFT FIFO and writes payloads to SRAM
module fifo_sram_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4,
  parameter int SRAM_AW    = 10
) (
  input logic clk,
  input logic rst_n,
  fifo_sram_writer_if.master bus
);
  typedef enum logic [1:0] {IDLE, ALLOC, WRITE, DONE} state_t;
  state_t state, nstate;
  logic [DATA_WIDTH-1:0] head;
  logic [LEN_WIDTH-1:0] hdr_len, len, cnt;
  logic [SRAM_AW-1:0] base;
  logic pop_hdr, fire, last;
  assign head    = bus.fifo_dout;
  assign hdr_len = head[LEN_WIDTH-1:0];
  assign pop_hdr = state == IDLE && !bus.fifo_empty;
  assign fire    = state == WRITE && !bus.fifo_empty && bus.sram_ready;
  assign last    = fire && cnt == len - LEN_WIDTH'(1);
  // combinational outputs are gated by rst_n so nothing leaks out while reset is held
  always_comb begin
    nstate         = state;
    bus.fifo_rd_en = 1'b0;
    bus.alloc_req  = 1'b0;
    bus.sram_wr_en = 1'b0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    nstate = state == IDLE  ? (pop_hdr && hdr_len != '0 ? ALLOC : IDLE) :
             state == ALLOC ? (bus.alloc_gnt ? WRITE : ALLOC) :
             state == WRITE ? (last ? DONE : WRITE) : IDLE;
    bus.fifo_rd_en = rst_n && (pop_hdr || fire);
    bus.alloc_req  = rst_n && state == ALLOC;
    bus.sram_wr_en = rst_n && fire;
    bus.sram_addr  = rst_n ? base + SRAM_AW'(cnt) : '0;
    bus.sram_wdata = rst_n ? head : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      len          <= '0;
      cnt          <= '0;
      base         <= '0;
      bus.pkt_done <= 1'b0;
      bus.hdr_err  <= 1'b0;
      bus.pkt_base <= '0;
      bus.pkt_len  <= '0;
    end else begin
      state        <= nstate;
      bus.pkt_done <= last;
      bus.hdr_err  <= pop_hdr && hdr_len == '0;
      if (pop_hdr) len <= hdr_len;
      if (state == ALLOC && bus.alloc_gnt) begin
        base <= bus.alloc_addr;
        cnt  <= '0;
      end else if (fire) cnt <= cnt + 1'b1;
      if (last) begin
        bus.pkt_base <= base;
        bus.pkt_len  <= len;
      end
    end
  end
endmodule

// File: tb/tb_fifo_sram_writer.sv
// tb_fifo_sram_writer: directed scenarios against an FWFT FIFO model and scripted allocator
module tb_fifo_sram_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_sram_writer_if #(.DATA_WIDTH(8), .LEN_WIDTH(4), .SRAM_AW(10)) bus();
  fifo_sram_writer #(.DATA_WIDTH(8), .LEN_WIDTH(4), .SRAM_AW(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0, fails = 0;
  int cyc = 0, nw = 0, npd = 0, nhe = 0, nreq = 0, pdc = 0, wp = 0, rp = 0;
  logic [7:0] mem [256];
  logic [9:0] wa [256];
  logic [7:0] wd [256];
  int wc [256];
  logic tog = 1'b0;
  logic [36:0] outs;

  assign outs = {bus.fifo_rd_en, bus.alloc_req, bus.sram_wr_en, bus.pkt_done, bus.hdr_err,
                 bus.pkt_base, bus.pkt_len, bus.sram_addr, bus.sram_wdata};
  assign bus.fifo_empty = (rp == wp);
  assign bus.fifo_dout  = mem[rp[7:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.fifo_rd_en && !bus.fifo_empty) rp <= rp + 1;
  end

  initial begin
    bus.sram_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.sram_ready = tog ? ~bus.sram_ready : 1'b1;
    end
  end

  // every pop or write must happen on a cycle where it is legal
  always @(negedge clk) begin
    if (bus.fifo_rd_en || bus.sram_wr_en) begin
      checks++;
      if (bus.fifo_empty || (bus.sram_wr_en && !bus.sram_ready)) begin
        fails++;
        $display("FAIL protocol: cyc %0d rd_en=%b wr_en=%b empty=%b ready=%b, required no pop/write when stalled",
                 cyc, bus.fifo_rd_en, bus.sram_wr_en, bus.fifo_empty, bus.sram_ready);
      end
    end
    if (bus.sram_wr_en) begin
      wa[nw] = bus.sram_addr;
      wd[nw] = bus.sram_wdata;
      wc[nw] = cyc;
      nw++;
    end
    if (bus.pkt_done) begin
      npd++;
      pdc = cyc;
    end
    if (bus.hdr_err) nhe++;
    if (bus.alloc_req) nreq++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] w);
    mem[wp[7:0]] = w;
    wp = wp + 1;
  endtask

  task automatic grant(input logic [9:0] a, input int d);
    int t = 0;
    while (!bus.alloc_req && t < 50) begin
      step();
      t++;
    end
    checks++;
    if (!bus.alloc_req) begin
      fails++;
      $display("FAIL alloc_req_timeout: got alloc_req=0 after %0d cycles, expected 1", t);
    end
    repeat (d) step();
    bus.alloc_gnt  = 1'b1;
    bus.alloc_addr = a;
    step();
    bus.alloc_gnt  = 1'b0;
    bus.alloc_addr = 10'h0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!bus.pkt_done && t < 100) begin
      step();
      t++;
    end
    checks++;
    if (!bus.pkt_done) begin
      fails++;
      $display("FAIL pkt_done_timeout: got pkt_done=0 after %0d cycles, expected 1", t);
    end
    step();
    checks++;
    if (bus.pkt_done !== 1'b0) begin
      fails++;
      $display("FAIL pkt_done_pulse: got %b one cycle later, expected 0", bus.pkt_done);
    end
  endtask

  task automatic test_reset();
    bus.alloc_gnt  = 1'b1;
    bus.alloc_addr = 10'h3AB;
    push(8'h03); push(8'hA1); push(8'hA2); push(8'hA3);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (outs !== 37'h0) begin
        fails++;
        $display("FAIL reset_outputs: cycle %0d got %h, expected 0", i, outs);
      end
      checks++;
      if (rp !== 0) begin
        fails++;
        $display("FAIL reset_no_pop: got rp=%0d, expected 0", rp);
      end
    end
    bus.alloc_gnt  = 1'b0;
    bus.alloc_addr = 10'h0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int w0 = nw, p0 = npd, r0 = nreq;
    logic [7:0] ed [3] = '{8'hA1, 8'hA2, 8'hA3};
    grant(10'h040, 2);
    wait_done();
    checks++;
    if (nw - w0 !== 3 || npd - p0 !== 1 || nreq - r0 !== 3) begin
      fails++;
      $display("FAIL basic_counts: got writes=%0d done=%0d req_cycles=%0d, expected 3 1 3", nw - w0, npd - p0, nreq - r0);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wa[w0+i] !== 10'h040 + 10'(i) || wd[w0+i] !== ed[i]) begin
        fails++;
        $display("FAIL basic_write%0d: got %h/%h, expected %h/%h", i, wa[w0+i], wd[w0+i], 10'h040 + 10'(i), ed[i]);
      end
    end
    checks++;
    if (wc[w0+1] - wc[w0] !== 1 || wc[w0+2] - wc[w0+1] !== 1 || pdc - wc[w0+2] !== 1) begin
      fails++;
      $display("FAIL basic_timing: got gaps %0d %0d done_gap %0d, expected 1 1 1",
               wc[w0+1] - wc[w0], wc[w0+2] - wc[w0+1], pdc - wc[w0+2]);
    end
    checks++;
    if (bus.pkt_base !== 10'h040 || bus.pkt_len !== 4'd3) begin
      fails++;
      $display("FAIL basic_report: got base=%h len=%0d, expected 040 3", bus.pkt_base, bus.pkt_len);
    end
  endtask

  task automatic test_backpressure();
    int w0 = nw, p0 = npd, n1, t = 0;
    logic [7:0] ed [4] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    tog = 1'b1;
    push(8'h04); push(8'hC1); push(8'hC2);
    grant(10'h100, 0);
    while (nw - w0 < 2 && t < 50) begin
      step();
      t++;
    end
    n1 = nw;
    step();
    step();
    checks++;
    if (nw !== n1 || n1 - w0 !== 2) begin
      fails++;
      $display("FAIL bp_empty_stall: got writes %0d then %0d, expected 2 then 2", n1 - w0, nw - w0);
    end
    push(8'hC3); push(8'hC4);
    wait_done();
    tog = 1'b0;
    checks++;
    if (nw - w0 !== 4 || npd - p0 !== 1) begin
      fails++;
      $display("FAIL bp_counts: got writes=%0d done=%0d, expected 4 1", nw - w0, npd - p0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wa[w0+i] !== 10'h100 + 10'(i) || wd[w0+i] !== ed[i]) begin
        fails++;
        $display("FAIL bp_write%0d: got %h/%h, expected %h/%h", i, wa[w0+i], wd[w0+i], 10'h100 + 10'(i), ed[i]);
      end
    end
    checks++;
    if (wc[w0+1] - wc[w0] !== 2) begin
      fails++;
      $display("FAIL bp_ready_stall: got gap %0d, expected 2", wc[w0+1] - wc[w0]);
    end
    checks++;
    if (bus.pkt_base !== 10'h100 || bus.pkt_len !== 4'd4) begin
      fails++;
      $display("FAIL bp_report: got base=%h len=%0d, expected 100 4", bus.pkt_base, bus.pkt_len);
    end
  endtask

  task automatic test_zero_len();
    int w0 = nw, h0 = nhe, r0 = nreq;
    push(8'h00); push(8'h01); push(8'hB1);
    grant(10'h200, 0);
    wait_done();
    checks++;
    if (nhe - h0 !== 1) begin
      fails++;
      $display("FAIL zero_hdr_err: got %0d pulses, expected 1", nhe - h0);
    end
    checks++;
    if (nreq - r0 !== 1) begin
      fails++;
      $display("FAIL zero_no_alloc: got %0d req cycles, expected 1", nreq - r0);
    end
    checks++;
    if (nw - w0 !== 1 || wa[w0] !== 10'h200 || wd[w0] !== 8'hB1) begin
      fails++;
      $display("FAIL zero_write: got n=%0d %h/%h, expected 1 200/b1", nw - w0, wa[w0], wd[w0]);
    end
    checks++;
    if (bus.pkt_len !== 4'd1 || bus.pkt_base !== 10'h200) begin
      fails++;
      $display("FAIL zero_report: got base=%h len=%0d, expected 200 1", bus.pkt_base, bus.pkt_len);
    end
  endtask

  task automatic test_wrap();
    int w0 = nw;
    logic [9:0] ea [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    push(8'hA4); push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    grant(10'h3FE, 1);
    wait_done();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wa[w0+i] !== ea[i]) begin
        fails++;
        $display("FAIL wrap_addr%0d: got %h, expected %h", i, wa[w0+i], ea[i]);
      end
    end
    checks++;
    if (bus.pkt_base !== 10'h3FE || bus.pkt_len !== 4'd4) begin
      fails++;
      $display("FAIL wrap_report: got base=%h len=%0d, expected 3fe 4", bus.pkt_base, bus.pkt_len);
    end
  endtask

  task automatic test_reset_mid();
    int w0 = nw, p0 = npd, r1, t = 0;
    push(8'h05); push(8'h11); push(8'h22); push(8'h02); push(8'h44); push(8'h55);
    grant(10'h050, 0);
    while (nw - w0 < 2 && t < 50) begin
      step();
      t++;
    end
    rst_n = 1'b0;
    r1 = rp;
    #1;
    checks++;
    if (outs[36:33] !== 4'b0 || outs[17:0] !== 18'h0) begin
      fails++;
      $display("FAIL mid_reset_comb: got %h, expected strobes and bus 0", outs);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (outs !== 37'h0) begin
        fails++;
        $display("FAIL mid_reset_outputs: got %h, expected 0", outs);
      end
    end
    checks++;
    if (npd !== p0 || nw - w0 !== 2 || rp !== r1) begin
      fails++;
      $display("FAIL mid_reset_abandon: got done=%0d writes=%0d pops=%0d, expected 0 2 0", npd - p0, nw - w0, rp - r1);
    end
    rst_n = 1'b1;
    w0 = nw;
    grant(10'h060, 0);
    wait_done();
    checks++;
    if (nw - w0 !== 2 || wa[w0] !== 10'h060 || wd[w0] !== 8'h44 || wa[w0+1] !== 10'h061 || wd[w0+1] !== 8'h55) begin
      fails++;
      $display("FAIL mid_reset_reparse: got n=%0d %h/%h %h/%h, expected 2 060/44 061/55",
               nw - w0, wa[w0], wd[w0], wa[w0+1], wd[w0+1]);
    end
    checks++;
    if (bus.pkt_base !== 10'h060 || bus.pkt_len !== 4'd2) begin
      fails++;
      $display("FAIL mid_reset_report: got base=%h len=%0d, expected 060 2", bus.pkt_base, bus.pkt_len);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.alloc_gnt  = 1'b0;
    bus.alloc_addr = 10'h0;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_wrap();
    test_reset_mid();
    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
